// File: rtl/icu_pkg.sv
// rtl/icu_pkg.sv - shared constants and arbitration helper for the 80186-style interrupt control unit
package icu_pkg;

  localparam int NSRC = 5;

  localparam logic [3:0] OFF_EOI    = 4'h1;
  localparam logic [3:0] OFF_MASK   = 4'h4;
  localparam logic [3:0] OFF_PRIMSK = 4'h5;
  localparam logic [3:0] OFF_INSERV = 4'h6;
  localparam logic [3:0] OFF_REQST  = 4'h7;
  localparam logic [3:0] OFF_TCUCON = 4'h9;
  localparam logic [3:0] OFF_I0CON  = 4'hC;

  localparam int SRC_TMR  = 0;
  localparam int SRC_INT0 = 1;
  localparam int SRC_INT1 = 2;
  localparam int SRC_INT2 = 3;
  localparam int SRC_INT3 = 4;

  localparam int CON_PRI_MSB = 2;
  localparam int CON_MSK     = 3;
  localparam int CON_LTM     = 4;
  localparam int EOI_NSPEC   = 15;

  typedef struct packed {
    logic       hit;
    logic [2:0] src;
    logic [2:0] pri;
  } pick_t;

  // Lowest numeric priority wins; the strict compare keeps the lower source index on ties.
  function automatic pick_t pick(input logic [NSRC-1:0] cand, input logic [NSRC-1:0][2:0] pri);
    pick_t p;
    p = '0;
    p.pri = 3'd7;
    for (int i = 0; i < NSRC; i++) begin
      if (cand[i] && (!p.hit || pri[i] < p.pri)) begin
        p.hit = 1'b1;
        p.src = 3'(i);
        p.pri = pri[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/icu_edge_sync.sv
// rtl/icu_edge_sync.sv - per-input request conditioning: optional 2-flop synchronizer (ICU_SYNC_EN),
// rising-edge detect and level/edge mode select
module icu_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic ltm,
  output logic set,
  output logic level
);

  logic sync;
  logic prev;

`ifdef ICU_SYNC_EN
  logic [1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) meta <= '0;
    else     meta <= {meta[0], raw};
  end

  assign sync = meta[1];
`else
  assign sync = raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= sync;
  end

  assign set   = sync & ~prev & ~ltm;
  assign level = sync;

endmodule

// File: rtl/wb_icu80186.sv
// rtl/wb_icu80186.sv - Wishbone interrupt control unit: masked, prioritised, nestable timer + INT0..INT3.
// ICU_SYNC_EN adds a 2-flop synchronizer on each ext_irq input.
module wb_icu80186
  import icu_pkg::*;
#(
  parameter logic [7:0] VEC_TMR    = 8'd8,
  parameter logic [7:0] VEC_INT0   = 8'd12,
  parameter logic [2:0] RST_PRIMSK = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        tmr_irq,
  input  logic [3:0]  ext_irq,
  output logic        intr,
  input  logic        inta,
  output logic [7:0]  vector
);

  logic [NSRC-1:0][2:0] pri;
  logic [NSRC-1:0]      msk, reqst, insrv, elig, ack_set, eoi_clr, edge_set, lvl_mode, lvl_val;
  logic [3:0]           ltm, ext_set, ext_lvl;
  logic [2:0]           primsk, icon_src;
  logic                 inta_d, tmr_d, bus_req, wr_lo, wr_hi, inta_rise;
  logic [15:0]          rdata;
  logic [3:0]           isr_floor;
  pick_t                isr_top, win;

  for (genvar k = 0; k < 4; k++) begin : g_ext
    icu_edge_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .raw   (ext_irq[k]),
      .ltm   (ltm[k]),
      .set   (ext_set[k]),
      .level (ext_lvl[k])
    );
  end

  function automatic logic [7:0] vec_of(input logic [2:0] src);
    return (src == 3'(SRC_TMR)) ? VEC_TMR : VEC_INT0 + 8'(src) - 8'd1;
  endfunction

  assign bus_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_lo    = wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i & wb_sel_i[0];
  assign wr_hi    = wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i & wb_sel_i[1];
  assign icon_src = {1'b0, wb_adr_i[1:0]} + 3'd1;
  assign edge_set = {ext_set, tmr_irq & ~tmr_d};
  assign lvl_mode = {ltm, 1'b0};
  assign lvl_val  = {ext_lvl, 1'b0};

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      OFF_MASK:   rdata[NSRC-1:0] = msk;
      OFF_PRIMSK: rdata[2:0]      = primsk;
      OFF_INSERV: rdata[NSRC-1:0] = insrv;
      OFF_REQST:  rdata[NSRC-1:0] = reqst;
      OFF_TCUCON: rdata[3:0]      = {msk[SRC_TMR], pri[SRC_TMR]};
      default:
        if (wb_adr_i[3:2] == OFF_I0CON[3:2])
          rdata[4:0] = {ltm[wb_adr_i[1:0]], msk[icon_src], pri[icon_src]};
    endcase
  end

  // A source must beat the lowest numeric priority already in service to nest.
  assign isr_top   = pick(insrv, pri);
  assign isr_floor = isr_top.hit ? {1'b0, isr_top.pri} : 4'd8;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NSRC; i++)
      elig[i] = reqst[i] & ~msk[i] & (pri[i] <= primsk) & ({1'b0, pri[i]} < isr_floor);
  end

  assign win       = pick(elig, pri);
  assign inta_rise = inta & ~inta_d;
  assign ack_set   = (inta_rise & win.hit) ? (5'b00001 << win.src) : '0;

  always_comb begin
    eoi_clr = '0;
    if (wb_adr_i == OFF_EOI) begin
      if (wr_hi && wb_dat_i[EOI_NSPEC]) begin
        if (isr_top.hit) eoi_clr[isr_top.src] = 1'b1;
      end else if (wr_lo) begin
        for (int i = 0; i < NSRC; i++)
          if (vec_of(3'(i)) == {3'b000, wb_dat_i[4:0]}) eoi_clr[i] = insrv[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      intr     <= 1'b0;
      vector   <= VEC_INT0;
      inta_d   <= 1'b0;
      tmr_d    <= 1'b0;
      reqst    <= '0;
      insrv    <= '0;
      msk      <= '1;
      pri      <= '1;
      ltm      <= '0;
      primsk   <= RST_PRIMSK;
    end else begin
      wb_ack_o <= bus_req;
      wb_dat_o <= bus_req ? rdata : '0;
      inta_d   <= inta;
      tmr_d    <= tmr_irq;
      intr     <= win.hit & ~inta;
      if (inta_rise) vector <= win.hit ? vec_of(win.src) : VEC_INT0 + 8'd3;
      insrv <= (insrv & ~eoi_clr) | ack_set;
      for (int i = 0; i < NSRC; i++)
        reqst[i] <= lvl_mode[i] ? lvl_val[i] : (edge_set[i] | (reqst[i] & ~ack_set[i]));
      if (wr_lo) begin
        case (wb_adr_i)
          OFF_MASK:   msk    <= wb_dat_i[NSRC-1:0];
          OFF_PRIMSK: primsk <= wb_dat_i[2:0];
          OFF_TCUCON: begin
            pri[SRC_TMR] <= wb_dat_i[CON_PRI_MSB:0];
            msk[SRC_TMR] <= wb_dat_i[CON_MSK];
          end
          default:
            if (wb_adr_i[3:2] == OFF_I0CON[3:2]) begin
              pri[icon_src]       <= wb_dat_i[CON_PRI_MSB:0];
              msk[icon_src]       <= wb_dat_i[CON_MSK];
              ltm[wb_adr_i[1:0]]  <= wb_dat_i[CON_LTM];
            end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_icu80186.sv
// tb/tb_wb_icu80186.sv - self-checking bench for wb_icu80186 with an architectural model
module tb_wb_icu80186;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic        tmr_irq = 1'b0;
  logic [3:0]  ext_irq = '0;
  logic        intr;
  logic        inta = 1'b0;
  logic [7:0]  vector;

  always #5 clk = ~clk;

  wb_icu80186 dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o),
    .tmr_irq  (tmr_irq),
    .ext_irq  (ext_irq),
    .intr     (intr),
    .inta     (inta),
    .vector   (vector)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Architectural model: sources 0=TMR, 1..4=INT0..INT3.
  int         m_pri[5];
  bit         m_msk[5];
  bit         m_req[5];
  bit         m_isr[5];
  bit         m_ltm[4];
  bit         m_ext[4];
  int         m_primsk;
  logic [7:0] m_vec;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int vec_of(input int s);
    return (s == 0) ? 8 : 12 + s - 1;
  endfunction

  function automatic bit req_eff(input int s);
    if (s > 0 && m_ltm[s-1]) return m_ext[s-1];
    return m_req[s];
  endfunction

  function automatic int m_win();
    int floor_p = 8;
    int w = -1;
    for (int s = 0; s < 5; s++)
      if (m_isr[s] && m_pri[s] < floor_p) floor_p = m_pri[s];
    for (int s = 0; s < 5; s++)
      if (req_eff(s) && !m_msk[s] && m_pri[s] <= m_primsk && m_pri[s] < floor_p &&
          (w < 0 || m_pri[s] < m_pri[w])) w = s;
    return w;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    logic [15:0] r;
    r = '0;
    case (a)
      4'h4: for (int s = 0; s < 5; s++) r[s] = m_msk[s];
      4'h5: r[2:0] = 3'(m_primsk);
      4'h6: for (int s = 0; s < 5; s++) r[s] = m_isr[s];
      4'h7: for (int s = 0; s < 5; s++) r[s] = req_eff(s);
      4'h9: r[3:0] = {m_msk[0], 3'(m_pri[0])};
      4'hC, 4'hD, 4'hE, 4'hF: r[4:0] = {m_ltm[a[1:0]], m_msk[a[1:0]+1], 3'(m_pri[a[1:0]+1])};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic m_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] sel);
    if (a == 4'h1) begin
      if (sel[1] && d[15]) begin
        int b;
        b = -1;
        for (int s = 0; s < 5; s++)
          if (m_isr[s] && (b < 0 || m_pri[s] < m_pri[b])) b = s;
        if (b >= 0) m_isr[b] = 1'b0;
      end else if (sel[0]) begin
        for (int s = 0; s < 5; s++)
          if (m_isr[s] && vec_of(s) == int'(d[4:0])) m_isr[s] = 1'b0;
      end
    end else if (sel[0]) begin
      case (a)
        4'h4: for (int s = 0; s < 5; s++) m_msk[s] = d[s];
        4'h5: m_primsk = int'(d[2:0]);
        4'h9: begin m_pri[0] = int'(d[2:0]); m_msk[0] = d[3]; end
        4'hC, 4'hD, 4'hE, 4'hF: begin
          m_pri[a[1:0]+1] = int'(d[2:0]);
          m_msk[a[1:0]+1] = d[3];
          m_ltm[a[1:0]]   = d[4];
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("intr_vs_model", 16'(intr), 16'(m_win() >= 0 && !inta));
      check("vector_vs_model", 16'(vector), 16'(m_vec));
    end
  end

  task automatic settle();
    repeat (6) @(posedge clk);
    #1 chk_en = 1'b1;
  endtask

  task automatic wb(input logic [3:0] a, input bit we, input logic [15:0] d,
                    input logic [1:0] sel, output logic [15:0] rd);
    bit got;
    got = 1'b0;
    chk_en = 1'b0;
    @(negedge clk);
    wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk);
      #1 got = wb_ack_o;
    end
    check("wb_ack_seen", 16'(got), 16'd1);
    rd = wb_dat_o;
    if (!we) check("rd_vs_model", rd, m_read(a));
    @(posedge clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check("ack_one_cycle", 16'(wb_ack_o), 16'd0);
    if (we) m_write(a, d, sel);
    settle();
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    logic [15:0] rd;
    wb(a, 1'b1, d, 2'b11, rd);
  endtask

  task automatic rd_lit(input string name, input logic [3:0] a, input logic [15:0] lit);
    logic [15:0] rd;
    wb(a, 1'b0, 16'h0, 2'b11, rd);
    check(name, rd, lit);
  endtask

  task automatic pulse(input bit t, input logic [3:0] e);
    chk_en = 1'b0;
    @(negedge clk);
    tmr_irq = t;
    ext_irq = ext_irq | e;
    @(negedge clk);
    tmr_irq = 1'b0;
    ext_irq = ext_irq & ~e;
    if (t) m_req[0] = 1'b1;
    for (int k = 0; k < 4; k++)
      if (e[k] && !m_ltm[k]) m_req[k+1] = 1'b1;
    settle();
  endtask

  task automatic set_ext(input int k, input bit v);
    chk_en = 1'b0;
    @(negedge clk);
    ext_irq[k] = v;
    m_ext[k] = v;
    settle();
  endtask

  task automatic do_ack();
    int w;
    chk_en = 1'b0;
    @(negedge clk);
    inta = 1'b1;
    w = m_win();
    if (w >= 0) begin
      m_isr[w] = 1'b1;
      if (!(w > 0 && m_ltm[w-1])) m_req[w] = 1'b0;
      m_vec = 8'(vec_of(w));
    end else begin
      m_vec = 8'h0F;
    end
    settle();
    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    @(negedge clk);
    inta = 1'b0;
    settle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 5; s++) begin
      m_pri[s] = 7; m_msk[s] = 1'b1; m_req[s] = 1'b0; m_isr[s] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      m_ltm[k] = 1'b0; m_ext[k] = 1'b0;
    end
    m_primsk = 7;
    m_vec = 8'h0C;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 16'(wb_ack_o), 16'd0);
    check("rst_dat", wb_dat_o, 16'h0000);
    check("rst_intr", 16'(intr), 16'd0);
    check("rst_vector", 16'(vector), 16'h000C);
    @(negedge clk);
    rst = 1'b0;
    settle();

    rd_lit("rst_mask", 4'h4, 16'h001F);
    rd_lit("rst_i0con", 4'hC, 16'h000F);

    // INT0 edge request and acknowledge
    wr(4'hC, 16'h0002);
    chk_en = 1'b0;
    @(negedge clk);
    ext_irq[0] = 1'b1;
    m_req[1] = 1'b1;
    @(negedge clk);
    ext_irq[0] = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 5 && !seen; n++) begin
        @(posedge clk);
        #1 seen = intr;
      end
      check("int0_intr_latency", 16'(seen), 16'd1);
    end
    settle();
    rd_lit("int0_reqst", 4'h7, 16'h0002);
    do_ack();
    check("int0_vector", 16'(vector), 16'h000C);
    check("int0_intr_after_ack", 16'(intr), 16'd0);
    rd_lit("int0_inserv", 4'h6, 16'h0002);
    wr(4'h1, 16'h000C);
    rd_lit("int0_eoi", 4'h6, 16'h0000);

    // TMR pri 5 and INT1 pri 2 raised together
    wr(4'h9, 16'h0005);
    wr(4'hD, 16'h0002);
    pulse(1'b1, 4'b0010);
    do_ack();
    check("nest_first_vec", 16'(vector), 16'h000D);
    check("nest_tmr_blocked", 16'(intr), 16'd0);
    do_ack();
    check("spurious_vec", 16'(vector), 16'h000F);
    rd_lit("spurious_inserv", 4'h6, 16'h0004);
    rd_lit("spurious_reqst", 4'h7, 16'h0001);
    wr(4'h1, 16'h000D);
    check("tmr_intr_after_eoi", 16'(intr), 16'd1);
    do_ack();
    check("tmr_vec", 16'(vector), 16'h0008);
    rd_lit("tmr_inserv", 4'h6, 16'h0001);
    wr(4'h1, 16'h8000);

    // INT2 level mode
    wr(4'hE, 16'h0011);
    set_ext(2, 1'b1);
    rd_lit("lvl_reqst_high", 4'h7, 16'h0008);
    do_ack();
    check("lvl_vec", 16'(vector), 16'h000E);
    rd_lit("lvl_reqst_after_ack", 4'h7, 16'h0008);
    set_ext(2, 1'b0);
    rd_lit("lvl_reqst_drop", 4'h7, 16'h0000);
    wr(4'h1, 16'h000E);

    // priority mask threshold
    wr(4'h5, 16'h0001);
    wr(4'hF, 16'h0003);
    pulse(1'b0, 4'b1000);
    check("primsk_blocks", 16'(intr), 16'd0);
    wr(4'h5, 16'h0003);
    check("primsk_allows", 16'(intr), 16'd1);
    do_ack();
    check("int3_vec", 16'(vector), 16'h000F);
    wr(4'h1, 16'h000F);

    // nested INT0 then INT1, non-specific EOI
    wr(4'hD, 16'h0001);
    pulse(1'b0, 4'b0001);
    do_ack();
    pulse(1'b0, 4'b0010);
    do_ack();
    check("nested_vec", 16'(vector), 16'h000D);
    rd_lit("nested_inserv", 4'h6, 16'h0006);
    wr(4'h1, 16'h8000);
    rd_lit("nspec_eoi_inserv", 4'h6, 16'h0002);

    // byte selects and unmapped offsets
    begin
      logic [15:0] rd;
      wb(4'h4, 1'b1, 16'h001F, 2'b10, rd);
      rd_lit("mask_hi_sel_only", 4'h4, 16'h0000);
      wb(4'h4, 1'b1, 16'h001F, 2'b01, rd);
      rd_lit("mask_lo_sel", 4'h4, 16'h001F);
    end
    rd_lit("tcucon_alias", 4'h9, 16'h000D);
    rd_lit("unmapped_read", 4'h2, 16'h0000);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_icu80186.md
Name: wb_icu80186

Overview:
- 80186-style interrupt control unit: a Wishbone slave on the 0xFF20–0xFF3E I/O window.
- Sits directly upstream of the zet core's interrupt request input (wb_tgc_i) and consumes its interrupt acknowledge (wb_tgc_o).
- Replaces the fixed tube-IRQ edge latch and the hard-wired vector 0x0C with masked, prioritised, nestable handling of one timer source and four external sources (INT0 = tube IRQ).
- Presents the acknowledged vector for the top-level inta data mux.

Parameters:
- VEC_TMR, 8, vector type for timer request.
- VEC_INT0, 12, vector type for INT0; INT1..INT3 use VEC_INT0+1..+3.
- RST_PRIMSK, 3'd7, reset value of the priority mask register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wb_adr_i  in  4  word address within window (byte offset [4:1])
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_sel_i  in  2  byte selects
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  acknowledge
- tmr_irq  in  1  timer request, synchronous one-cycle pulse
- ext_irq  in  4  INT3..INT0 raw inputs, active high
- intr  out  1  interrupt request to core
- inta  in  1  interrupt acknowledge from core
- vector  out  8  vector type of last acknowledged source

Behaviour:
- Reset (async, rst=1). Outputs:
  - wb_ack_o=0, wb_dat_o=0, intr=0, vector=VEC_INT0.
- Reset state of internal registers:
  - REQST=0, INSERV=0, MASK=5'h1F (all masked).
  - PRIMSK=RST_PRIMSK.
  - Each control register = 4'b1111 (priority 7, masked, edge mode).
  - Edge detectors cleared.
- Register map (word offset → register):
  - 0x1 EOI (write only).
  - 0x4 MASK[4:0].
  - 0x5 PRIMSK[2:0].
  - 0x6 INSERV[4:0], read-only.
  - 0x7 REQST[4:0], read-only.
  - 0x9 TCUCON: [2:0] priority, [3] mask.
  - 0xC..0xF I0CON..I3CON: [2:0] priority, [3] mask, [4] LTM (1 = level).
  - Bit order in MASK/INSERV/REQST: [0]=TMR, [1..4]=INT0..INT3.
  - MASK aliases the per-source control mask bits; writing either updates both.
  - Unlisted offsets read 0 and ignore writes.
- Wishbone:
  - wb_ack_o registered; asserts the cycle after cyc&stb&~ack, one cycle wide. Single-cycle latency; no wait states.
  - wb_dat_o valid with ack.
  - Writes commit on the ack cycle.
  - Low byte is written only if sel[0]; high byte only if sel[1].
- Request capture:
  - Edge mode: a 0→1 transition sets REQST bit. The bit clears on acknowledge of that source.
  - Level mode: REQST bit mirrors the synchronized input.
  - TMR is always edge (pulse) mode.
- Eligibility: a source is eligible if REQST=1, mask=0, priority < PRIMSK… specifically priority <= PRIMSK, and priority strictly less than the lowest numeric priority currently in service.
- Arbitration:
  - Lowest numeric priority wins.
  - Ties are broken by fixed order TMR > INT0 > INT1 > INT2 > INT3.
  - Winner is recomputed combinationally each cycle.
- intr:
  - Registered: intr <= any eligible source.
  - Drops the cycle after the inta rising edge.
  - Cannot reassert until inta is low.
- inta handshake:
  - The rising edge of inta (registered detect) latches the winner. This sets its INSERV bit, clears its edge REQST bit, and loads vector.
  - vector holds until the next acknowledge.
  - If there is no eligible winner at the inta edge (spurious), vector = VEC_INT0+3, and INSERV/REQST are unchanged.
- EOI write:
  - bit15=1 (non-specific) clears the in-service bit with highest priority, using the same tie order.
  - bit15=0 clears the source whose vector type equals bits[4:0]; unmatched types are ignored.
  - EOI with INSERV=0 has no effect.
- Simultaneous events:
  - A new edge on the same cycle as acknowledge of that source leaves REQST=1.
  - EOI and inta on the same cycle: EOI clear applies first, then the acknowledge set.
- rst asserted mid-bus-cycle: ack drops immediately; the write is lost.

Optional Feature:
- ICU_SYNC_EN defined: each ext_irq bit passes a 2-flop synchronizer before edge/level detection. This adds 2 cycles of latency.
- ICU_SYNC_EN undefined: ext_irq is treated as already synchronous, with 1 flop for edge detect only.

Decomposition:
- Package icu_pkg holds:
  - register word offsets;
  - source index constants (SRC_TMR=0, SRC_INT0..3=1..4);
  - control-register field positions;
  - EOI non-specific bit index.
- Sub-module icu_edge_sync: one instance per ext_irq bit. It holds the optional synchronizer, edge detect and LTM select, and outputs a set pulse and a level.

Test Plan:
- Reset, read MASK (0x4) → 0x001F; read I0CON (0xC) → 0x000F; intr=0.
- Write I0CON=0x0002, then pulse ext_irq[0] → REQST=0x0002 and intr=1 within 4 cycles (sync on). Raise inta → vector=0x0C, INSERV=0x0002, intr=0.
- Unmask TMR at priority 5 and INT1 at priority 2, then pulse both on the same cycle → first ack vector=0x0D. Do not send EOI; next ack gives no TMR while INT1 is in service. EOI=0x000D → intr=1, ack vector=0x08.
- INT2 in level mode (I2CON=0x0011): hold ext_irq[2]=1 → REQST[3] stays 1 after ack. Drop ext_irq[2] → REQST[3]=0.
- Set PRIMSK=1 and INT3 at priority 3, then pulse INT3 → intr stays 0. Set PRIMSK=3 → intr=1.
- INSERV=0x0006 (INT0 priority 2, INT1 priority 1); write EOI=0x8000 → INSERV=0x0002. Write with sel=2'b10 to MASK → MASK unchanged.
